// File: rtl/dwt_row_scheduler.sv
// -----------------------------------------------------------------------------
// dwt_row_scheduler
//   Frame sequencer feeding the row-direction 9/7 DWT stream input. A start
//   walks a frame held in pair-wide line memory row by row, issues reads and
//   presents each pair as a stream beat with sof/eol framing. Every row is
//   followed by FlushPairs pad beats (re-reading the row's last pair) so the
//   row filter pipeline drains before the next row begins.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             begin a frame (sampled only while idle)
//   abort_i             synchronous abort: drop the frame, return to idle
//   cfg_width_i         row width in pairs (W), legal 2..MaximumSideSize/2
//   cfg_height_i        row count (H), legal 1..MaximumSideSize
//   busy_o              frame in progress
//   done_o              1-cycle pulse the cycle after the final beat handshake
//   cfg_err_o           1-cycle pulse after a start with an illegal W/H
//   rd_en_o, rd_addr_o  memory read strobe / pair address (row*W + col)
//   rd_data_i           read data, valid the cycle after rd_en_o
//   m_ready_i           downstream ready
//   m_valid_o, m_sof_o, m_eol_o, m_data_o   output stream beat {odd, even}
//
// Handshake: a beat transfers on a cycle where m_valid_o & m_ready_i. While
//   m_valid_o is high and m_ready_i low, m_data_o/m_sof_o/m_eol_o hold steady.
//   m_valid_o never drops without a transfer except on abort or reset.
// -----------------------------------------------------------------------------
module dwt_row_scheduler #(
  parameter int DataWidth       = 16,
  parameter int MaximumSideSize = 512,
  parameter int FlushPairs      = 4,
  parameter int AddrWidth       = $clog2(MaximumSideSize*MaximumSideSize/2),
  localparam int WBits          = $clog2(MaximumSideSize/2+1),
  localparam int HBits          = $clog2(MaximumSideSize+1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [WBits-1:0]       cfg_width_i,
  input  logic [HBits-1:0]       cfg_height_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   cfg_err_o,
  output logic                   rd_en_o,
  output logic [AddrWidth-1:0]   rd_addr_o,
  input  logic [2*DataWidth-1:0] rd_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);

  localparam int BBits = $clog2(MaximumSideSize/2 + FlushPairs);
  localparam int BeatW = 2*DataWidth;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                 state_q;
  logic [WBits-1:0]       w_q;
  logic [HBits-1:0]       h_q;
  logic [BBits-1:0]       b_q;
  logic [HBits-1:0]       row_q;
  logic [AddrWidth-1:0]   addr_q;
  logic                   done_q;
  logic                   cfg_err_q;

  // One-stage tag pipe matching the memory latency.
  logic                   inflight_q;
  logic                   tag_sof_q;
  logic                   tag_eol_q;

  // Two-entry output FIFO, entries are {sof, eol, data}.
  logic [BeatW+1:0]       fifo_q [2];
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             count_q;

  logic                   cfg_ok;
  logic                   credit_ok;
  logic                   issue;
  logic [BBits-1:0]       last_b;
  logic [BBits-1:0]       last_col_b;
  logic                   beat_sof;
  logic                   beat_eol;
  logic                   row_last;
  logic                   addr_step;
  logic [BeatW+1:0]       out_beat;
  logic                   hs;
  logic                   push;
  logic                   pop_fifo;
  logic                   last_out;
  logic                   do_abort;

  assign cfg_ok = (cfg_width_i >= WBits'(2)) &&
                  (cfg_width_i <= WBits'(MaximumSideSize/2)) &&
                  (cfg_height_i >= HBits'(1)) &&
                  (cfg_height_i <= HBits'(MaximumSideSize));

  // A new read is allowed only while FIFO entries plus the read in flight
  // leave room for its data, so the FIFO can never overflow.
  assign credit_ok = (count_q == 2'd0) || ((count_q == 2'd1) && !inflight_q);
  assign issue     = (state_q == S_RUN) && credit_ok;

  assign last_b     = BBits'(w_q) + BBits'(FlushPairs - 1);
  assign last_col_b = BBits'(w_q) - BBits'(1);
  assign beat_sof   = (row_q == '0) && (b_q == '0);
  assign beat_eol   = (b_q == last_b);
  assign row_last   = (row_q == (h_q - HBits'(1)));

  // The address tracks the column and holds during pad beats. Stepping once
  // more at the row's last beat lands on base+W, i.e. the next row's base.
  assign addr_step = (b_q < last_col_b) || beat_eol;

  assign do_abort = abort_i && (state_q != S_IDLE);

  // Output comes from the FIFO head, or straight from memory when the FIFO is
  // empty so the first beat shows up in the cycle its data returns.
  assign out_beat  = (count_q != 2'd0) ? fifo_q[rd_ptr_q]
                                       : {tag_sof_q, tag_eol_q, rd_data_i};
  assign m_valid_o = (count_q != 2'd0) || inflight_q;
  assign m_sof_o   = m_valid_o & out_beat[BeatW+1];
  assign m_eol_o   = m_valid_o & out_beat[BeatW];
  assign m_data_o  = m_valid_o ? out_beat[BeatW-1:0] : '0;

  assign hs       = m_valid_o && m_ready_i;
  assign pop_fifo = m_ready_i && (count_q != 2'd0);
  // Returning data is stored unless it was bypassed and accepted right away.
  assign push     = inflight_q && ((count_q != 2'd0) || !m_ready_i);
  assign last_out = ((count_q == 2'd1) && !inflight_q) ||
                    ((count_q == 2'd0) && inflight_q);

  assign rd_en_o   = issue;
  assign rd_addr_o = addr_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign cfg_err_o = cfg_err_q;

  // Frame sequencing FSM and row/beat counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      b_q       <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (do_abort) begin
        state_q <= S_IDLE;
        b_q     <= '0;
        row_q   <= '0;
        addr_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              if (cfg_ok) begin
                state_q <= S_RUN;
                w_q     <= cfg_width_i;
                h_q     <= cfg_height_i;
                b_q     <= '0;
                row_q   <= '0;
                addr_q  <= '0;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (issue) begin
              if (addr_step) addr_q <= addr_q + AddrWidth'(1);
              if (beat_eol) begin
                b_q   <= '0;
                row_q <= row_q + HBits'(1);
                if (row_last) state_q <= S_DRAIN;
              end else begin
                b_q <= b_q + BBits'(1);
              end
            end
          end
          S_DRAIN: begin
            if (hs && last_out) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Tag pipe and output FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      tag_sof_q  <= 1'b0;
      tag_eol_q  <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else if (do_abort) begin
      inflight_q <= 1'b0;
      tag_sof_q  <= 1'b0;
      tag_eol_q  <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_sof_q <= beat_sof;
        tag_eol_q <= beat_eol;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= {tag_sof_q, tag_eol_q, rd_data_i};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_fifo) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

endmodule
